// File: rtl/ctrl_issue_sequencer.sv
// rtl/ctrl_issue_sequencer.sv - feeds opcodes to the control decoder and issues registered control words
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   in_valid/in_ready/in_op opcode input handshake (in_ready is combinational from out_ready/flush)
//   flush                   drop the pending, not-yet-issued opcode
//   dec_op/dec_ctrl         registered opcode out to the external decoder, combinational result back
//   out_valid/out_ready     control word handshake to the datapath
//   out_ctrl                registered control word
//   busy                    multi-cycle operation in progress
//   issued_cnt              wrap-around count of issued control words

module ctrl_issue_sequencer #(
  parameter int OP_W      = 7,
  parameter int CTRL_W    = 26,
  parameter int MC_BIT    = 21,
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  output logic              in_ready,
  input  logic              flush,
  output logic [OP_W-1:0]   dec_op,
  input  logic [CTRL_W-1:0] dec_ctrl,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  issued_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ISSUE  = 2'd2,
    S_BUSY   = 2'd3
  } state_t;

  // Busy lasts MC_CYCLES cycles: the counter is loaded with MC_CYCLES-1 and
  // the state leaves BUSY on the edge after it reads zero.
  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [3:0]          mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ctrl_q   <= '0;
      mc_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ctrl_q   <= ctrl_d;
      mc_cnt_q <= mc_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ctrl_d    = ctrl_q;
    mc_cnt_d  = mc_cnt_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A flush in IDLE blocks acceptance for that cycle.
        in_ready = ~flush;
        if (in_valid && !flush) begin
          op_d    = in_op;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // The decoder has had a full cycle on op_q; capture its result.
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          ctrl_d  = dec_ctrl;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        out_valid = 1'b1;
        if (flush) begin
          // Flush beats a same-cycle handshake: nothing is issued or counted.
          state_d = S_IDLE;
        end else if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (ctrl_q[MC_BIT]) begin
            mc_cnt_d = MC_LOAD;
            state_d  = S_BUSY;
          end else begin
            // Back-to-back accept keeps one word per two cycles.
            in_ready = 1'b1;
            if (in_valid) begin
              op_d    = in_op;
              state_d = S_DECODE;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_BUSY: begin
        busy = 1'b1;
        if (mc_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          mc_cnt_d = mc_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dec_op     = op_q;
  assign out_ctrl   = ctrl_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_issue_sequencer.sv
// tb/tb_ctrl_issue_sequencer.sv - directed and random checks of ctrl_issue_sequencer against a transaction-timing model

module tb_ctrl_issue_sequencer;

  localparam int OP_W      = 7;
  localparam int CTRL_W    = 26;
  localparam int MC_BIT    = 21;
  localparam int MC_CYCLES = 4;
  localparam int CNT_W     = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic              in_ready;
  logic              flush;
  logic [OP_W-1:0]   dec_op;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  issued_cnt;

  always #5 clock = ~clock;

  ctrl_issue_sequencer #(
    .OP_W(OP_W), .CTRL_W(CTRL_W), .MC_BIT(MC_BIT),
    .MC_CYCLES(MC_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_op(in_op), .in_ready(in_ready),
    .flush(flush),
    .dec_op(dec_op), .dec_ctrl(dec_ctrl),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_ready(out_ready),
    .busy(busy), .issued_cnt(issued_cnt)
  );

  // Stand-in decoder: opcodes 0x50..0x5F are multi-cycle.
  function automatic logic [CTRL_W-1:0] dec_fn(input logic [OP_W-1:0] op);
    logic [CTRL_W-1:0] w;
    w = {op, ~op, op ^ 7'h35, op[4:0] ^ 5'h0B};
    w[MC_BIT] = (op[6:4] == 3'b101);
    return w;
  endfunction

  assign dec_ctrl = dec_fn(dec_op);

  int ncmp = 0;
  int nfail = 0;

  // Model: a pending word is accepted in cycle pend_t, is valid from
  // pend_t+2 until handshake or flush; a multi-cycle handshake in cycle n
  // makes busy true for cycles n+1 .. n+MC_CYCLES.
  int                n = 0;
  bit                m_known = 1'b0;
  bit                m_pend = 1'b0;
  int                m_pend_t = 0;
  logic [CTRL_W-1:0] m_pend_ctrl = '0;
  logic [CTRL_W-1:0] m_ctrl = '0;
  logic [OP_W-1:0]   m_op = '0;
  logic [CNT_W-1:0]  m_cnt = '0;
  int                m_busy_until = -1;
  bit                m_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [OP_W-1:0] op, input bit ordy,
                     input bit fl, input bit rst);
    bit e_ov, e_busy, e_rdy;
    in_valid  = v;
    in_op     = op;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #2;
    e_ov   = m_pend && (n >= m_pend_t + 2);
    e_busy = (n <= m_busy_until);
    e_rdy  = !fl && ((!m_pend && !e_busy) || (e_ov && ordy && !m_pend_ctrl[MC_BIT]));
    if (m_known) begin
      check("in_ready",   32'(in_ready),   32'(e_rdy));
      check("out_valid",  32'(out_valid),  32'(e_ov));
      check("busy",       32'(busy),       32'(e_busy));
      check("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
      check("dec_op",     32'(dec_op),     32'(m_op));
      check("out_ctrl",   32'(out_ctrl),   32'(m_ctrl));
    end
    m_acc = 1'b0;
    if (rst) begin
      m_known      = 1'b1;
      m_pend       = 1'b0;
      m_ctrl       = '0;
      m_op         = '0;
      m_cnt        = '0;
      m_busy_until = -1;
    end else if (m_known) begin
      if (fl) begin
        m_pend = 1'b0;
      end else begin
        if (m_pend && n == m_pend_t + 1) m_ctrl = m_pend_ctrl;
        if (e_ov && ordy) begin
          m_cnt++;
          m_pend = 1'b0;
          if (m_pend_ctrl[MC_BIT]) m_busy_until = n + MC_CYCLES;
        end
        if (v && e_rdy) begin
          m_acc       = 1'b1;
          m_pend      = 1'b1;
          m_pend_t    = n;
          m_pend_ctrl = dec_fn(op);
          m_op        = op;
        end
      end
    end
    @(posedge clock);
    #1;
    n++;
  endtask

  // Hold in_valid with op until it is accepted, within a cycle budget.
  task automatic send(input logic [OP_W-1:0] op, input bit ordy);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cyc(1'b1, op, ordy, 1'b0, 1'b0);
      got = m_acc;
    end
    ncmp++;
    assert (got) else begin
      nfail++;
      $error("FAIL accept_timeout observed=not_accepted expected=accepted op=%h", op);
    end
  endtask

  initial begin
    int bl;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clock);
    #1;

    // Reset
    cyc(0, 7'h00, 0, 0, 1);
    cyc(0, 7'h00, 0, 0, 1);
    check("rst_cnt",    32'(issued_cnt), 32'd0);
    check("rst_dec_op", 32'(dec_op),     32'd0);
    check("rst_ov",     32'(out_valid),  32'd0);
    check("rst_ctrl",   32'(out_ctrl),   32'd0);

    // Single opcode 05
    cyc(1, 7'h05, 1, 0, 0);
    check("t1_dec_op", 32'(dec_op), 32'h05);
    cyc(0, 7'h00, 1, 0, 0);
    check("t1_ov", 32'(out_valid), 32'd1);
    cyc(0, 7'h00, 1, 0, 0);
    check("t1_cnt",  32'(issued_cnt), 32'd1);
    check("t1_idle", 32'(out_valid),  32'd0);
    check("t1_ctrl", 32'(out_ctrl),   32'(dec_fn(7'h05)));

    // Stall 5 cycles with out_valid high
    cyc(1, 7'h07, 0, 0, 0);
    repeat (6) cyc(0, 7'h00, 0, 0, 0);
    check("stall_ov",   32'(out_valid), 32'd1);
    check("stall_ctrl", 32'(out_ctrl),  32'(dec_fn(7'h07)));
    check("stall_cnt",  32'(issued_cnt), 32'd1);
    cyc(0, 7'h00, 1, 0, 0);
    cyc(0, 7'h00, 1, 0, 0);
    check("stall_cnt2", 32'(issued_cnt), 32'd2);

    // Back-to-back stream
    send(7'h01, 1);
    send(7'h02, 1);
    send(7'h03, 1);
    repeat (3) cyc(0, 7'h00, 1, 0, 0);
    check("stream_cnt", 32'(issued_cnt), 32'd5);

    // Multi-cycle op then next op waiting out the busy period
    send(7'h55, 1);
    send(7'h09, 1);
    repeat (3) cyc(0, 7'h00, 1, 0, 0);
    check("mc_cnt", 32'(issued_cnt), 32'd7);

    // Flush in ISSUE with out_ready high
    send(7'h0A, 0);
    cyc(0, 7'h00, 0, 0, 0);
    cyc(0, 7'h00, 1, 1, 0);
    check("fl_issue_ov",  32'(out_valid),  32'd0);
    check("fl_issue_cnt", 32'(issued_cnt), 32'd7);

    // Flush in DECODE
    send(7'h0B, 1);
    cyc(0, 7'h00, 1, 1, 0);
    cyc(0, 7'h00, 1, 0, 0);
    check("fl_dec_ov", 32'(out_valid), 32'd0);

    // Flush in IDLE blocks acceptance
    cyc(1, 7'h0C, 1, 1, 0);
    cyc(0, 7'h00, 1, 0, 0);
    check("fl_idle_dec_op", 32'(dec_op), 32'h0B);

    // Flush in BUSY leaves busy length unchanged
    send(7'h5C, 1);
    cyc(0, 7'h00, 1, 0, 0);
    cyc(0, 7'h00, 1, 0, 0);
    bl = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy === 1'b1) bl++;
      cyc(0, 7'h00, 1, (k == 0), 0);
    end
    check("fl_busy_len", 32'(bl), 32'(MC_CYCLES));
    check("fl_busy_cnt", 32'(issued_cnt), 32'd8);

    // Counter wrap
    for (int i = 0; i < 247; i++) send(7'($urandom_range(0, 7'h4F)), 1);
    cyc(0, 7'h00, 1, 0, 0);
    cyc(0, 7'h00, 1, 0, 0);
    check("wrap_ff", 32'(issued_cnt), 32'hFF);
    send(7'h11, 1);
    cyc(0, 7'h00, 1, 0, 0);
    cyc(0, 7'h00, 1, 0, 0);
    check("wrap_00", 32'(issued_cnt), 32'h00);

    // Reset mid-BUSY
    send(7'h50, 1);
    cyc(0, 7'h00, 1, 0, 0);
    cyc(0, 7'h00, 1, 0, 0);
    check("mid_busy", 32'(busy), 32'd1);
    cyc(0, 7'h00, 1, 0, 1);
    check("rst_busy_busy", 32'(busy),       32'd0);
    check("rst_busy_ov",   32'(out_valid),  32'd0);
    check("rst_busy_cnt",  32'(issued_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [OP_W-1:0] op;
      op = ($urandom_range(0, 4) == 0) ? {3'b101, 4'($urandom)} : 7'($urandom);
      cyc(($urandom_range(0, 3) != 0), op, ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
